// File: rtl/core_mem_arb_pkg.sv
// rtl/core_mem_arb_pkg.sv - shared types and width helpers for the core memory arbiter
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic int calc_sel_w(input int core_count);
    return ($clog2(core_count) < 1) ? 1 : $clog2(core_count);
  endfunction

  function automatic int calc_cnt_w(input int mem_latency);
    return ($clog2(mem_latency) < 1) ? 1 : $clog2(mem_latency);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner search starting at ptr
module rr_priority_picker #(
  parameter int core_count = 4,
  parameter int sel_w      = 2
) (
  input  logic [core_count-1:0] req,
  input  logic [sel_w-1:0]      ptr,
  output logic [sel_w-1:0]      winner,
  output logic                  any_req
);

  localparam logic [sel_w:0] N_CORES = (sel_w+1)'(core_count);

  logic [2*core_count-1:0] req_dbl;
  logic [core_count-1:0]   window;
  logic [sel_w:0]          offset;
  logic [sel_w:0]          sum;

  // Duplicating req lets a plain slice starting at ptr act as a rotation.
  assign req_dbl = {req, req};
  assign window  = req_dbl[ptr +: core_count];
  assign any_req = |req;

  always_comb begin
    offset = '0;
    for (int i = core_count - 1; i >= 0; i--) begin
      if (window[i]) offset = (sel_w+1)'(i);
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= N_CORES) sum = sum - N_CORES;
    winner = sum[sel_w-1:0];
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing one single-port data memory among cores
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int reg_width   = 12,
  parameter int addr_width  = 12,
  parameter int core_count  = 4,
  parameter int mem_latency = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            req,
  input  logic [core_count-1:0]            we,
  input  logic [core_count*addr_width-1:0] addr,
  input  logic [core_count*reg_width-1:0]  wdata,
  output logic [core_count-1:0]            grant,
  output logic [core_count-1:0]            rvalid,
  output logic [reg_width-1:0]             rdata,
  output logic                             busy,
  output logic [addr_width-1:0]            mem_addr,
  output logic [reg_width-1:0]             mem_wdata,
  output logic                             mem_we,
  input  logic [reg_width-1:0]             mem_rdata
);

  localparam int SEL_W = calc_sel_w(core_count);
  localparam int CNT_W = calc_cnt_w(mem_latency);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(mem_latency - 1);
  localparam logic [SEL_W-1:0] LAST_CORE = SEL_W'(core_count - 1);

  arb_state_e              state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d, ptr_q, ptr_d, win;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_l_q, we_l_d, any_req;
  logic [addr_width-1:0]   mem_addr_q, mem_addr_d;
  logic [reg_width-1:0]    mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [addr_width-1:0]   addr_a  [core_count];
  logic [reg_width-1:0]    wdata_a [core_count];

  for (genvar i = 0; i < core_count; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*addr_width +: addr_width];
    assign wdata_a[i] = wdata[i*reg_width +: reg_width];
  end

  rr_priority_picker #(
    .core_count(core_count),
    .sel_w     (SEL_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win),
    .any_req(any_req)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    we_l_d      = we_l_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d       = win;
          mem_addr_d  = addr_a[win];
          mem_wdata_d = wdata_a[win];
          we_l_d      = we[win];
          ptr_d       = (win == LAST_CORE) ? '0 : win + SEL_W'(1);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (we_l_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Counter reaching zero marks cycle ISSUE+mem_latency, when mem_rdata is valid.
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      we_l_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      we_l_q      <= we_l_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    grant  = '0;
    rvalid = '0;
    if (state_q == ISSUE) grant[sel_q]  = 1'b1;
    if (state_q == RESP)  rvalid[sel_q] = 1'b1;
  end

  assign mem_we    = (state_q == ISSUE) && we_l_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed table and sequence checks of core_mem_arbiter at several configurations
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, we;
  logic [47:0] addr, wdata;
  logic [0:0]  req_d, we_d;
  logic [11:0] addr_d, wdata_d;

  logic [3:0]  grant_a, rvalid_a, grant_b, rvalid_b, grant_c, rvalid_c;
  logic [11:0] rdata_a, maddr_a, mwdata_a, mrdata_a;
  logic [11:0] rdata_b, maddr_b, mwdata_b, mrdata_b;
  logic [11:0] rdata_c, maddr_c, mwdata_c, mrdata_c;
  logic        busy_a, mwe_a, busy_b, mwe_b, busy_c, mwe_c;
  logic [0:0]  grant_dd, rvalid_dd;
  logic [11:0] rdata_dd, maddr_dd, mwdata_dd, mrdata_dd;
  logic        busy_dd, mwe_dd;

  logic        pipe_a = 1'b0;
  logic [1:0]  pipe_b = '0;
  logic [2:0]  pipe_c = '0;
  logic        pipe_d = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(.reg_width(12), .addr_width(12), .core_count(4), .mem_latency(1)) u_a (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant_a), .rvalid(rvalid_a), .rdata(rdata_a), .busy(busy_a),
    .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_we(mwe_a), .mem_rdata(mrdata_a));

  core_mem_arbiter #(.reg_width(12), .addr_width(12), .core_count(4), .mem_latency(2)) u_b (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant_b), .rvalid(rvalid_b), .rdata(rdata_b), .busy(busy_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_we(mwe_b), .mem_rdata(mrdata_b));

  core_mem_arbiter #(.reg_width(12), .addr_width(12), .core_count(4), .mem_latency(3)) u_c (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant_c), .rvalid(rvalid_c), .rdata(rdata_c), .busy(busy_c),
    .mem_addr(maddr_c), .mem_wdata(mwdata_c), .mem_we(mwe_c), .mem_rdata(mrdata_c));

  core_mem_arbiter #(.reg_width(12), .addr_width(12), .core_count(1), .mem_latency(1)) u_d (
    .clk(clk), .reset(reset), .req(req_d), .we(we_d), .addr(addr_d), .wdata(wdata_d),
    .grant(grant_dd), .rvalid(rvalid_dd), .rdata(rdata_dd), .busy(busy_dd),
    .mem_addr(maddr_dd), .mem_wdata(mwdata_dd), .mem_we(mwe_dd), .mem_rdata(mrdata_dd));

  // Memory models: read data is only valid exactly mem_latency cycles after ISSUE.
  always @(posedge clk) begin
    pipe_a <= (|grant_a) & ~mwe_a;
    pipe_b <= {pipe_b[0], (|grant_b) & ~mwe_b};
    pipe_c <= {pipe_c[1:0], (|grant_c) & ~mwe_c};
    pipe_d <= (|grant_dd) & ~mwe_dd;
  end
  assign mrdata_a  = pipe_a    ? (maddr_a  ^ 12'h3C2) : 12'hEEE;
  assign mrdata_b  = pipe_b[1] ? (maddr_b  ^ 12'h3C2) : 12'hEEE;
  assign mrdata_c  = pipe_c[2] ? (maddr_c  ^ 12'h3C2) : 12'hEEE;
  assign mrdata_dd = pipe_d    ? (maddr_dd ^ 12'h3C2) : 12'hEEE;

  typedef struct {
    logic [3:0]  req, we, grant, rvalid;
    logic        mem_we, busy;
    logic [11:0] addr, wdata, rdata;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] r, w, g, rv, input logic mw, b,
                     input logic [11:0] a, d, rd);
    vec_t v;
    v.req = r; v.we = w; v.grant = g; v.rvalid = rv; v.mem_we = mw; v.busy = b;
    v.addr = a; v.wdata = d; v.rdata = rd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req = '0; we = '0; req_d = '0; we_d = '0;
    addr  = {12'h013, 12'h01A, 12'h011, 12'h010};
    wdata = {12'hD03, 12'hABC, 12'hD01, 12'hD00};
    addr_d = 12'h0AA; wdata_d = 12'h5A5;

    // round robin from reset, all cores writing
    add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b1111, 4'b1111, 4'b0001, 4'b0000, 1, 1, 12'h010, 12'hD00, 12'h000);
    add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b1111, 4'b1111, 4'b0010, 4'b0000, 1, 1, 12'h011, 12'hD01, 12'h000);
    add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b1111, 4'b1111, 4'b0100, 4'b0000, 1, 1, 12'h01A, 12'hABC, 12'h000);
    add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b1111, 4'b1111, 4'b1000, 4'b0000, 1, 1, 12'h013, 12'hD03, 12'h000);
    add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b1111, 4'b1111, 4'b0001, 4'b0000, 1, 1, 12'h010, 12'hD00, 12'h000);
    add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    // single write by core 2
    add(4'b0100, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b0100, 4'b1111, 4'b0100, 4'b0000, 1, 1, 12'h01A, 12'hABC, 12'h000);
    add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    // pointer fairness: cores 0 and 3 after core 2 served
    add(4'b1001, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b1001, 4'b1111, 4'b1000, 4'b0000, 1, 1, 12'h013, 12'hD03, 12'h000);
    add(4'b0001, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b0001, 4'b1111, 4'b0001, 4'b0000, 1, 1, 12'h010, 12'hD00, 12'h000);
    add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    // single read by core 1 at latency 1
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);
    add(4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 1, 12'h011, 12'hD01, 12'h000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 12'h000, 12'h000, 12'h000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 1, 12'h000, 12'h000, 12'h3D3);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 12'h000, 12'h000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", 32'(grant_a), 0);
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_mem", 32'({mwe_a, maddr_a, mwdata_a}), 0);
    chk("reset_rsp", 32'({rvalid_a, rdata_a}), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      we  = tbl[i].we;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), 32'(grant_a), 32'(tbl[i].grant));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid_a), 32'(tbl[i].rvalid));
      chk($sformatf("v%0d_mem_we", i), 32'(mwe_a), 32'(tbl[i].mem_we));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
      if (tbl[i].grant != 4'b0000) begin
        chk($sformatf("v%0d_mem_addr", i), 32'(maddr_a), 32'(tbl[i].addr));
        chk($sformatf("v%0d_mem_wdata", i), 32'(mwdata_a), 32'(tbl[i].wdata));
      end
      if (tbl[i].rvalid != 4'b0000)
        chk($sformatf("v%0d_rdata", i), 32'(rdata_a), 32'(tbl[i].rdata));
      next_cycle();
    end
    repeat (3) next_cycle();

    // latency-2 read by core 1
    addr[12 +: 12] = 12'h005;
    req = 4'b0010; we = 4'b0000;
    @(negedge clk); chk("b_c0_grant", 32'(grant_b), 0);
    next_cycle();
    @(negedge clk); chk("b_c1_grant", 32'(grant_b), 32'h2);
    next_cycle(); req = '0;
    @(negedge clk); chk("b_c2_rvalid", 32'(rvalid_b), 0);
    next_cycle();
    @(negedge clk); chk("b_c3_rvalid", 32'(rvalid_b), 0);
    next_cycle();
    @(negedge clk); chk("b_c4_rvalid", 32'(rvalid_b), 32'h2);
    chk("b_c4_rdata", 32'(rdata_b), 32'h3C7);
    next_cycle();
    @(negedge clk); chk("b_c5_idle", 32'({busy_b, rvalid_b}), 0);
    next_cycle();

    // reset during WAIT at latency 3
    addr[24 +: 12] = 12'h020;
    req = 4'b0100; we = 4'b0000;
    next_cycle();
    @(negedge clk); chk("c_grant", 32'(grant_c), 32'h4);
    next_cycle(); req = '0;
    @(negedge clk); chk("c_wait_busy", 32'(busy_c), 1);
    reset = 1'b1;
    #1;
    chk("c_rst_ctrl", 32'({grant_c, rvalid_c, busy_c, mwe_c}), 0);
    chk("c_rst_mem_addr", 32'(maddr_c), 0);
    chk("c_rst_mem_wdata", 32'(mwdata_c), 0);
    chk("c_rst_rdata", 32'(rdata_c), 0);
    #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("c_no_rvalid%0d", k), 32'({rvalid_c, busy_c}), 0);
    end
    next_cycle();
    req = 4'b1010; we = 4'b1010;
    next_cycle();
    @(negedge clk); chk("c_after_rst_grant", 32'(grant_c), 32'h2);
    chk("c_after_rst_addr", 32'(maddr_c), 32'h005);
    next_cycle(); req = 4'b1000;
    next_cycle();
    @(negedge clk); chk("c_next_grant", 32'(grant_c), 32'h8);
    next_cycle(); req = '0;
    repeat (4) next_cycle();

    // single core: read then write
    req_d = 1'b1; we_d = 1'b0;
    @(negedge clk); chk("d_c0_grant", 32'(grant_dd), 0);
    next_cycle();
    @(negedge clk); chk("d_c1_grant", 32'({grant_dd, mwe_dd}), 32'h2);
    next_cycle(); req_d = 1'b0;
    @(negedge clk); chk("d_c2_rvalid", 32'(rvalid_dd), 0);
    next_cycle();
    @(negedge clk); chk("d_c3_rvalid", 32'(rvalid_dd), 1);
    chk("d_c3_rdata", 32'(rdata_dd), 32'h368);
    next_cycle(); req_d = 1'b1; we_d = 1'b1;
    @(negedge clk); chk("d_c4_idle", 32'({grant_dd, busy_dd}), 0);
    next_cycle();
    @(negedge clk); chk("d_c5_grant", 32'({grant_dd, mwe_dd}), 32'h3);
    chk("d_c5_wdata", 32'(mwdata_dd), 32'h5A5);
    next_cycle(); req_d = 1'b0;
    @(negedge clk); chk("d_c6_idle", 32'(busy_dd), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
